// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, issues single outstanding word fetches, hands instructions to decode and follows branch redirects
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_valid,
   input  logic        br_is_jump,
   input  logic        brq,
   input  logic [31:0] br_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        misalign_err
);
   typedef enum logic [2:0] {BOOT, FETCH, WAIT, DROP, HOLD} state_t;
   state_t state, state_nx;
   logic [31:0] pc, pc_nx, instr_nx, ipc_nx, target;
   logic take, redirect, misalign;
   assign take = br_valid & (br_is_jump | brq);
   assign misalign = take & br_target[1];
   assign redirect = take & ~br_target[1];
   assign target = br_target & 32'hFFFF_FFFC;
   assign imem_req_valid = (state == FETCH);
   assign imem_addr = pc;
   assign if_valid = (state == HOLD);
   // state, PC and decode-side registers; misalign_err is a registered one-cycle pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         if_instr     <= NOP_INSTR;
         if_pc        <= 32'h0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nx;
         pc           <= pc_nx;
         if_instr     <= instr_nx;
         if_pc        <= ipc_nx;
         misalign_err <= misalign;
      end
   end
   // next-state logic; a redirect overrides every other event in its cycle
   always_comb begin
      state_nx = state;
      pc_nx    = redirect ? target : pc;
      instr_nx = if_instr;
      ipc_nx   = if_pc;
      case (state)
         BOOT:  state_nx = FETCH;
         FETCH: state_nx = imem_req_ready ? (redirect ? DROP : WAIT) : FETCH;
         WAIT: begin
            if (redirect) begin
               state_nx = imem_rsp_valid ? FETCH : DROP;
            end else if (imem_rsp_valid) begin
               instr_nx = imem_rsp_data;
               ipc_nx   = pc;
               pc_nx    = pc + 32'd4;
               state_nx = HOLD;
            end
         end
         DROP:  state_nx = imem_rsp_valid ? FETCH : DROP;
         HOLD: begin
            if (redirect | if_ready) begin
               state_nx = FETCH;
               instr_nx = NOP_INSTR;
            end
         end
         default: state_nx = BOOT;
      endcase
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scoreboard bench for fetch_pc_unit with a latency-configurable memory model
module tb_fetch_pc_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic clk = 1'b0;
   logic rst_n, br_valid, br_is_jump, brq, imem_req_ready, imem_rsp_valid, if_ready;
   logic [31:0] br_target, imem_rsp_data;
   logic imem_req_valid, if_valid, misalign_err;
   logic [31:0] imem_addr, if_instr, if_pc, addr_l, mon_pc;
   int checks = 0, errors = 0, lat = 1, cnt;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_xfer[$];

   fetch_pc_unit #(.RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_is_jump(br_is_jump), .brq(brq),
      .br_target(br_target), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // memory model: responds lat cycles after acceptance, reset together with the DUT
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= 32'h0;
         addr_l         <= 32'h0;
         cnt            <= 0;
      end else begin
         imem_rsp_valid <= 1'b0;
         if (cnt == 1) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mem_word(addr_l);
         end
         if (cnt != 0) cnt <= cnt - 1;
         if (imem_req_valid && imem_req_ready) begin
            addr_l <= imem_addr;
            if (lat == 1) begin
               imem_rsp_valid <= 1'b1;
               imem_rsp_data  <= mem_word(imem_addr);
               cnt            <= 0;
            end else begin
               cnt <= lat - 1;
            end
         end
      end
   end

   // monitor: compares accepted fetch addresses and decode transfers against the expected queues
   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_req_valid && imem_req_ready) begin
            if (exp_addr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_fetch: got %h expected none", imem_addr);
            end else check("fetch_addr", imem_addr, exp_addr.pop_front());
         end
         if (if_valid && if_ready && !(br_valid && (br_is_jump || brq) && !br_target[1])) begin
            if (exp_xfer.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_xfer: got pc %h expected none", if_pc);
            end else begin
               mon_pc = exp_xfer.pop_front();
               check("if_pc", if_pc, mon_pc);
               check("if_instr", if_instr, mem_word(mon_pc));
            end
         end
      end
   end

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk);
         if (exp_addr.size() == 0 && exp_xfer.size() == 0) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0", exp_addr.size(), exp_xfer.size());
         exp_addr.delete();
         exp_xfer.delete();
      end
      #1 imem_req_ready = 1'b0;
   endtask

   task automatic wait_hold();
      bit done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(posedge clk);
         #1 if (if_valid) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL hold_timeout: got if_valid 0 expected 1");
      end
   endtask

   task automatic wait_accept();
      bit done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no accept expected one");
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; br_valid = 1'b0; br_is_jump = 1'b0; brq = 1'b0; br_target = 32'h0;
      imem_req_ready = 1'b0; if_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_instr", if_instr, NOP);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_misalign", 32'(misalign_err), 32'd0);
      check("rst_addr", imem_addr, 32'h100);
      // sequential stream from RESET_PC
      exp_addr = '{32'h100, 32'h104, 32'h108};
      exp_xfer = '{32'h100, 32'h104, 32'h108};
      imem_req_ready = 1'b1;
      if_ready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("boot_req_valid", 32'(imem_req_valid), 32'd0);
      drain();
      // taken branch while waiting: old-path response dropped
      lat = 2;
      exp_addr = '{32'h10C, 32'h200};
      exp_xfer = '{32'h200};
      imem_req_ready = 1'b1;
      wait_accept();
      br_valid = 1'b1; brq = 1'b1; br_target = 32'h200;
      @(posedge clk);
      #1 br_valid = 1'b0; brq = 1'b0;
      @(negedge clk);
      check("drop_req_valid", 32'(imem_req_valid), 32'd0);
      check("drop_addr", imem_addr, 32'h200);
      check("drop_if_valid", 32'(if_valid), 32'd0);
      drain();
      lat = 1;
      // not-taken branch in HOLD: transfer proceeds, PC continues +4
      exp_addr = '{32'h204, 32'h208};
      exp_xfer = '{32'h204, 32'h208};
      if_ready = 1'b0;
      imem_req_ready = 1'b1;
      wait_hold();
      br_valid = 1'b1; brq = 1'b0; br_is_jump = 1'b0; br_target = 32'h500; if_ready = 1'b1;
      @(posedge clk);
      #1 br_valid = 1'b0;
      drain();
      // jump in HOLD with decode ready: no transfer, bit 0 of target cleared
      exp_addr = '{32'h20C, 32'h3000};
      exp_xfer = '{32'h3000};
      if_ready = 1'b0;
      imem_req_ready = 1'b1;
      wait_hold();
      br_valid = 1'b1; br_is_jump = 1'b1; br_target = 32'h3001; if_ready = 1'b1;
      @(posedge clk);
      #1 br_valid = 1'b0; br_is_jump = 1'b0;
      @(negedge clk);
      check("jump_if_valid", 32'(if_valid), 32'd0);
      check("jump_if_instr", if_instr, NOP);
      check("jump_addr", imem_addr, 32'h3000);
      drain();
      // misaligned redirect suppressed, one-cycle error pulse
      br_valid = 1'b1; br_is_jump = 1'b1; br_target = 32'h402;
      @(negedge clk);
      check("mis_before", 32'(misalign_err), 32'd0);
      @(posedge clk);
      #1 br_valid = 1'b0; br_is_jump = 1'b0;
      @(negedge clk);
      check("mis_pulse", 32'(misalign_err), 32'd1);
      check("mis_addr", imem_addr, 32'h3004);
      check("mis_req_valid", 32'(imem_req_valid), 32'd1);
      @(negedge clk);
      check("mis_after", 32'(misalign_err), 32'd0);
      @(posedge clk);
      #1;
      exp_addr = '{32'h3004};
      exp_xfer = '{32'h3004};
      imem_req_ready = 1'b1;
      drain();
      // unaccepted redirect to the top word, request backpressure, decode backpressure, wrap
      br_valid = 1'b1; br_is_jump = 1'b1; br_target = 32'hFFFF_FFFC;
      @(posedge clk);
      #1 br_valid = 1'b0; br_is_jump = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_req_valid", 32'(imem_req_valid), 32'd1);
         check("bp_addr", imem_addr, 32'hFFFF_FFFC);
      end
      @(posedge clk);
      #1;
      exp_addr = '{32'hFFFF_FFFC, 32'h0};
      exp_xfer = '{32'hFFFF_FFFC, 32'h0};
      if_ready = 1'b0;
      imem_req_ready = 1'b1;
      wait_hold();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_if_valid", 32'(if_valid), 32'd1);
         check("bp_if_pc", if_pc, 32'hFFFF_FFFC);
         check("bp_if_instr", if_instr, 32'h3F21_FFFC);
      end
      @(posedge clk);
      #1 if_ready = 1'b1;
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
